cfg_chain_driver: RTL and testbench
===================================

Name: cfg_chain_driver

Overview:
- Host-side transmitter for the fabric serial configuration chain; drives the start/bit/valid triple consumed by the first tile's config block.
- Accepts a frame command (target ID + word count) and a stream of 16-bit config words over ready/valid.
- Serialises each frame as a start pulse, then the ID header, then the payload bits.
- Sits between the SoC config port and the first CLB/switch tile in the chain.

Parameters:
- ID_WIDTH, 3, width of tile ID header; must match the config blocks in the chain.
- WORD_W, 16, payload word width; equals the config block shift length.
- LEN_W, 8, width of the word-count field; max 2^LEN_W-1 words per frame.
- BIT_DIV, 1, clocks per transmitted bit; legal range 1..255.

Ports:
- clk  in  1  config/fabric clock.
- crst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  frame command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_id  in  ID_WIDTH  target tile ID.
- cmd_len  in  LEN_W  payload words in the frame; 0 = header-only frame.
- wd_valid  in  1  payload word valid.
- wd_ready  out  1  payload word accepted when wd_valid & wd_ready.
- wd_data  in  WORD_W  payload word.
- cfg_out_start  out  1  one-cycle frame start pulse to the chain.
- cfg_bit_out  out  1  serial bit.
- cfg_bit_out_valid  out  1  qualifies cfg_bit_out.
- busy  out  1  high from command accept until the DONE cycle inclusive.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - All outputs 0 except cmd_ready=1.
  - Counters and word buffer cleared.
- States: IDLE -> START -> ID -> DATA -> (PARITY) -> DONE -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_id/cmd_len, set busy, go to START next cycle.
- START: cfg_out_start=1 for exactly one cycle, with cfg_bit_out_valid=0. Next state is ID.
- Bit slot: each bit occupies BIT_DIV cycles.
  - cfg_bit_out_valid=1 on the first cycle of the slot only.
  - cfg_bit_out holds its value for the whole slot.
  - With BIT_DIV=1, bits are back-to-back.
- ID: ID_WIDTH bits, MSB first. Then DATA if len>0, else PARITY (or DONE when the parity feature is absent).
- DATA buffering:
  - One-word buffer. wd_ready=1 in DATA while the buffer is empty.
  - Also wd_ready=1 in the last ID slot, for prefetch.
- DATA shifting:
  - Words are shifted LSB first.
  - The remaining-word counter decrements when a word's last bit is sent.
  - The prefetched next word continues without a gap.
- Underrun: if the buffer is empty at a slot boundary, the driver stalls.
  - Valid stays 0, the bit counter holds, and no partial slot is emitted.
  - Resumes on the cycle after the word is accepted.
- Frame size: exactly cmd_len*WORD_W payload bits are sent. Words are never accepted beyond cmd_len.
- DONE: done=1 and busy=1 for one cycle. Then IDLE; cmd_ready rises the following cycle.
- Command handling: cmd_valid outside IDLE is ignored, since cmd_ready=0.
- Reset mid-frame: immediate return to the reset state.
  - Nothing further is emitted; the chain sees a truncated frame.
  - Recovery relies on the next cfg_out_start.
- Latency: cmd accept at cycle 0, start pulse at cycle 1, first ID bit valid at cycle 2.

Optional Feature:
- Macro: CFG_CHAIN_DRIVER_PARITY_EN.
- Defined: PARITY state emits one extra bit slot after the last payload bit, or after the ID for len=0.
  - Value = even parity (XOR) over ID bits and payload bits.
- Undefined: no PARITY state. The frame is start + ID_WIDTH + len*WORD_W bits.

Test Plan:
- Reset mid-DATA:
  - Stimulus: assert crst_n=0 during DATA with BIT_DIV=1.
  - Response: all outputs 0 and cmd_ready=1 during reset; no valid after release until a new command.
  - Next command: its start pulse appears one cycle after accept.
- BIT_DIV=1, id=5, len=1, word 0xA5C3, parity off:
  - Start pulse at cycle 1.
  - ID bits 1,0,1 at cycles 2-4.
  - Payload bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 at cycles 5-20 (0xA5C3 LSB first).
  - done at cycle 21.
- BIT_DIV=3, id=2, len=0: valid pulses at cycles 2, 5, 8 with bits 0,1,0; bit held 3 cycles; done at cycle 11.
- len=2 with wd_valid withheld 4 cycles after word 1's last bit: exactly 4-cycle valid gap; total 32 payload bits; wd_ready never high after the 2nd accept.
- cmd_valid held during a frame: no second command accepted until the cycle after done.
- Parity on, id=7, len=1, word 0x0001: parity bit = 0, 4 set bits; done follows it.

Source files
------------

// File: rtl/cfg_chain_driver.sv
// Host-side serial configuration chain transmitter: start pulse, ID header (MSB first), payload words (LSB first).
// Optional trailing even-parity bit slot when CFG_CHAIN_DRIVER_PARITY_EN is defined.
module cfg_chain_driver #(
  parameter int ID_WIDTH = 3,
  parameter int WORD_W   = 16,
  parameter int LEN_W    = 8,
  parameter int BIT_DIV  = 1
) (
  input  logic                clk,
  input  logic                crst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ID_WIDTH-1:0] cmd_id,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [WORD_W-1:0]   wd_data,
  output logic                cfg_out_start,
  output logic                cfg_bit_out,
  output logic                cfg_bit_out_valid,
  output logic                busy,
  output logic                done
);

  localparam int MAX_BITS = (WORD_W > ID_WIDTH) ? WORD_W : ID_WIDTH;
  localparam int BC_W     = $clog2(MAX_BITS + 1);
  localparam int DIV_W    = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ID, S_DATA, S_PARITY, S_DONE
  } state_t;

`ifdef CFG_CHAIN_DRIVER_PARITY_EN
  localparam state_t S_TAIL = S_PARITY;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t state, state_nxt;

  logic [ID_WIDTH-1:0] id_q;
  logic [LEN_W-1:0]    len_rem;
  logic [LEN_W-1:0]    acc_rem;
  logic [WORD_W-1:0]   cur;
  logic [WORD_W-1:0]   buf_q;
  logic                cur_full;
  logic                buf_full;
  logic [BC_W-1:0]     bit_cnt;
  logic [DIV_W-1:0]    div_cnt;
`ifdef CFG_CHAIN_DRIVER_PARITY_EN
  logic                par;
`endif

  logic slot_end, id_last, word_last, cmd_fire, wd_fire, cur_done, emitting;

  // Handshakes: a transfer happens on any clock edge where valid & ready are both high;
  // ready never depends on valid, and a producer may hold valid for as long as it likes.
  assign slot_end  = (div_cnt == DIV_W'(BIT_DIV - 1));
  assign id_last   = (bit_cnt == BC_W'(ID_WIDTH - 1));
  assign word_last = (bit_cnt == BC_W'(WORD_W - 1));
  assign cmd_fire  = (state == S_IDLE) && cmd_valid;
  assign wd_fire   = wd_valid && wd_ready;
  assign cur_done  = (state == S_DATA) && cur_full && slot_end && word_last;

  always_ff @(posedge clk or negedge crst_n) begin
    if (!crst_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    cmd_ready         = 1'b0;
    wd_ready          = 1'b0;
    cfg_out_start     = 1'b0;
    cfg_bit_out       = 1'b0;
    busy              = 1'b1;
    done              = 1'b0;
    emitting          = 1'b0;
    case (state)
      S_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = S_START;
      end
      S_START: begin
        cfg_out_start = 1'b1;
        state_nxt     = S_ID;
      end
      S_ID: begin
        emitting    = 1'b1;
        cfg_bit_out = id_q[ID_WIDTH-1];
        // Prefetch the first word during the last header slot so payload follows without a gap.
        wd_ready    = id_last && !buf_full && (acc_rem != '0);
        if (slot_end && id_last) state_nxt = (len_rem != '0) ? S_DATA : S_TAIL;
      end
      S_DATA: begin
        wd_ready = !buf_full && (acc_rem != '0);
        if (cur_full) begin
          emitting    = 1'b1;
          cfg_bit_out = cur[0];
        end
        if (cur_done && (len_rem == LEN_W'(1))) state_nxt = S_TAIL;
      end
`ifdef CFG_CHAIN_DRIVER_PARITY_EN
      S_PARITY: begin
        emitting    = 1'b1;
        cfg_bit_out = par;
        if (slot_end) state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    cfg_bit_out_valid = emitting && (div_cnt == '0);
  end

  always_ff @(posedge clk or negedge crst_n) begin
    if (!crst_n) begin
      id_q     <= '0;
      len_rem  <= '0;
      acc_rem  <= '0;
      cur      <= '0;
      buf_q    <= '0;
      cur_full <= 1'b0;
      buf_full <= 1'b0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
`ifdef CFG_CHAIN_DRIVER_PARITY_EN
      par      <= 1'b0;
`endif
    end else if (cmd_fire) begin
      id_q     <= cmd_id;
      len_rem  <= cmd_len;
      acc_rem  <= cmd_len;
      cur_full <= 1'b0;
      buf_full <= 1'b0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
`ifdef CFG_CHAIN_DRIVER_PARITY_EN
      par      <= ^cmd_id;
`endif
    end else begin
      // An underrun leaves emitting low, so the slot timer parks at the slot boundary.
      if (emitting) div_cnt <= slot_end ? '0 : div_cnt + DIV_W'(1);
      else          div_cnt <= '0;
      if (emitting && slot_end) begin
        if (((state == S_ID) && id_last) || ((state == S_DATA) && word_last)) bit_cnt <= '0;
        else bit_cnt <= bit_cnt + BC_W'(1);
      end
      if ((state == S_ID) && slot_end) id_q <= id_q << 1;
      if (wd_fire) begin
        acc_rem <= acc_rem - LEN_W'(1);
`ifdef CFG_CHAIN_DRIVER_PARITY_EN
        par     <= par ^ (^wd_data);
`endif
      end
      if (cur_done) len_rem <= len_rem - LEN_W'(1);
      // cur is the shifting word; buf_q holds the next one so words chain back to back.
      if (!cur_full) begin
        if (wd_fire) begin
          cur      <= wd_data;
          cur_full <= 1'b1;
        end
      end else if (cur_done) begin
        if (buf_full) begin
          cur      <= buf_q;
          buf_full <= 1'b0;
        end else if (wd_fire) begin
          cur <= wd_data;
        end else begin
          cur_full <= 1'b0;
        end
      end else begin
        if ((state == S_DATA) && slot_end) cur <= cur >> 1;
        if (wd_fire) begin
          buf_q    <= wd_data;
          buf_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cfg_chain_driver.sv
// Bench for cfg_chain_driver: two instances (BIT_DIV=1 and BIT_DIV=3) checked against a frame-level timing model.
module tb_cfg_chain_driver;

  localparam int MAXC = 512;
  localparam int IDW  = 3;
`ifdef CFG_CHAIN_DRIVER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        clk, crst_n;
  logic        cmd_valid[2];
  logic [2:0]  cmd_id[2];
  logic [7:0]  cmd_len[2];
  logic        wd_valid[2];
  logic [15:0] wd_data[2];
  logic        cmd_ready[2], wd_ready[2], cfg_out_start[2], cfg_bit_out[2];
  logic        cfg_bit_out_valid[2], busy[2], done[2];

  int vectors, miscompares;

  logic [15:0] words[8];
  int          avail[8];
  logic obs_start[MAXC], obs_valid[MAXC], obs_bit[MAXC], obs_done[MAXC], obs_busy[MAXC], obs_ready[MAXC];
  logic exp_valid[MAXC], exp_bit[MAXC], exp_care[MAXC];

  cfg_chain_driver #(.BIT_DIV(1)) dut_div1 (
    .clk(clk), .crst_n(crst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_id(cmd_id[0]), .cmd_len(cmd_len[0]),
    .wd_valid(wd_valid[0]), .wd_ready(wd_ready[0]), .wd_data(wd_data[0]),
    .cfg_out_start(cfg_out_start[0]), .cfg_bit_out(cfg_bit_out[0]),
    .cfg_bit_out_valid(cfg_bit_out_valid[0]), .busy(busy[0]), .done(done[0])
  );

  cfg_chain_driver #(.BIT_DIV(3)) dut_div3 (
    .clk(clk), .crst_n(crst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_id(cmd_id[1]), .cmd_len(cmd_len[1]),
    .wd_valid(wd_valid[1]), .wd_ready(wd_ready[1]), .wd_data(wd_data[1]),
    .cfg_out_start(cfg_out_start[1]), .cfg_bit_out(cfg_bit_out[1]),
    .cfg_bit_out_valid(cfg_bit_out_valid[1]), .busy(busy[1]), .done(done[1])
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] pack(input int d);
    return {cmd_ready[d], wd_ready[d], cfg_out_start[d], cfg_bit_out[d],
            cfg_bit_out_valid[d], busy[d], done[d]};
  endfunction

  task automatic set_slot(input int t, input int div, input logic b);
    if (t < MAXC) exp_valid[t] = 1'b1;
    for (int k = 0; k < div; k++) begin
      if (t + k < MAXC) begin
        exp_bit[t+k]  = b;
        exp_care[t+k] = 1'b1;
      end
    end
  endtask

  // Drives one frame (cycle 0 = command accept) and checks the whole trace against the model.
  task automatic run_frame(input int d, input logic [2:0] id, input int len, input bit hold_cmd,
                           output int done_c);
    int div, wi, c, w, over_ready, done_exp, t, s, last;
    int acc_t[8];
    int fb_start, fb_valid, fb_bit, fb_done, fb_busy, fb_ready;
    logic p, e_busy;
    div = (d == 0) ? 1 : 3;
    wi = 0; over_ready = 0; done_c = -1;
    for (int i = 0; i < 8; i++) acc_t[i] = 0;
    for (int i = 0; i < MAXC; i++) begin
      obs_start[i] = 0; obs_valid[i] = 0; obs_bit[i] = 0; obs_done[i] = 0; obs_busy[i] = 0; obs_ready[i] = 0;
      exp_valid[i] = 0; exp_bit[i] = 0; exp_care[i] = 0;
    end
    @(negedge clk);
    w = 0;
    while (cmd_ready[d] !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    vectors++;
    if (cmd_ready[d] !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_cmd_ready d%0d: got %b want 1", d, cmd_ready[d]);
    end
    cmd_valid[d] = 1'b1; cmd_id[d] = id; cmd_len[d] = 8'(len); wd_valid[d] = 1'b0;
    c = 0;
    while (1) begin
      @(negedge clk);
      c++;
      if (!hold_cmd) cmd_valid[d] = 1'b0;
      else if (c == 1) begin
        cmd_id[d] = ~id;
        cmd_len[d] = 8'd0;
      end
      wd_valid[d] = (wi < len) && (c >= avail[(wi < 8) ? wi : 0]);
      wd_data[d]  = (wi < len) ? words[wi] : 16'($urandom);
      if (wi >= len && wd_ready[d] === 1'b1) over_ready++;
      if (wd_valid[d] && wd_ready[d] === 1'b1) begin
        acc_t[wi] = c;
        wi++;
      end
      obs_start[c] = cfg_out_start[d]; obs_valid[c] = cfg_bit_out_valid[d]; obs_bit[c] = cfg_bit_out[d];
      obs_done[c] = done[d]; obs_busy[c] = busy[d]; obs_ready[c] = cmd_ready[d];
      if (done_c < 0 && done[d] === 1'b1) done_c = c;
      if (done_c >= 0 && c >= done_c + 2) break;
      if (c >= MAXC - 1) break;
    end
    wd_valid[d] = 1'b0;
    cmd_valid[d] = 1'b0;
    vectors++;
    if (done_c < 0) begin
      miscompares++;
      $display("FAIL frame_timeout d%0d: no done within %0d cycles", d, MAXC);
      return;
    end
    // Model: slots laid end to end; a word cannot start before the cycle after its acceptance.
    t = 2;
    p = ^id;
    for (int i = 0; i < IDW; i++) begin
      set_slot(t, div, id[IDW-1-i]);
      t += div;
    end
    for (int wd = 0; wd < len; wd++) begin
      s = (acc_t[wd] + 1 > t) ? acc_t[wd] + 1 : t;
      for (int j = 0; j < 16; j++) begin
        set_slot(s + j * div, div, words[wd][j]);
        p ^= words[wd][j];
      end
      t = s + 16 * div;
    end
    if (PAR == 1) begin
      set_slot(t, div, p);
      t += div;
    end
    done_exp = t;
    fb_start = -1; fb_valid = -1; fb_bit = -1; fb_done = -1; fb_busy = -1; fb_ready = -1;
    last = done_c + 2;
    for (int k = 1; k <= last; k++) begin
      e_busy = (k <= done_exp) || (hold_cmd && k >= done_exp + 2);
      if (fb_start < 0 && obs_start[k] !== ((k == 1) || (hold_cmd && k == done_exp + 2))) fb_start = k;
      if (fb_valid < 0 && obs_valid[k] !== exp_valid[k]) fb_valid = k;
      if (fb_bit < 0 && exp_care[k] && obs_bit[k] !== exp_bit[k]) fb_bit = k;
      if (fb_done < 0 && obs_done[k] !== (k == done_exp)) fb_done = k;
      if (fb_busy < 0 && obs_busy[k] !== e_busy) fb_busy = k;
      if (fb_ready < 0 && obs_ready[k] !== !e_busy) fb_ready = k;
    end
    vectors += 9;
    if (fb_start >= 0) begin miscompares++; $display("FAIL start d%0d cycle %0d: got %b want %b", d, fb_start, obs_start[fb_start], !obs_start[fb_start]); end
    if (fb_valid >= 0) begin miscompares++; $display("FAIL bit_valid d%0d cycle %0d: got %b want %b", d, fb_valid, obs_valid[fb_valid], exp_valid[fb_valid]); end
    if (fb_bit >= 0) begin miscompares++; $display("FAIL bit_value d%0d cycle %0d: got %b want %b", d, fb_bit, obs_bit[fb_bit], exp_bit[fb_bit]); end
    if (fb_done >= 0) begin miscompares++; $display("FAIL done_pulse d%0d cycle %0d: got %b want %b", d, fb_done, obs_done[fb_done], !obs_done[fb_done]); end
    if (fb_busy >= 0) begin miscompares++; $display("FAIL busy d%0d cycle %0d: got %b want %b", d, fb_busy, obs_busy[fb_busy], !obs_busy[fb_busy]); end
    if (fb_ready >= 0) begin miscompares++; $display("FAIL cmd_ready d%0d cycle %0d: got %b want %b", d, fb_ready, obs_ready[fb_ready], !obs_ready[fb_ready]); end
    if (done_c !== done_exp) begin miscompares++; $display("FAIL done_cycle d%0d: got %0d want %0d", d, done_c, done_exp); end
    if (wi !== len) begin miscompares++; $display("FAIL words_accepted d%0d: got %0d want %0d", d, wi, len); end
    if (over_ready !== 0) begin miscompares++; $display("FAIL wd_ready_after_last d%0d: got %0d cycles want 0", d, over_ready); end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b1; wd_valid[d] = 1'b1; cmd_id[d] = 3'd5; cmd_len[d] = 8'd1; wd_data[d] = 16'hffff;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (pack(d) !== 7'b1000000) begin
        miscompares++;
        $display("FAIL reset_hold d%0d: got %b want 1000000", d, pack(d));
      end
      cmd_valid[d] = 1'b0; wd_valid[d] = 1'b0;
    end
    crst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (pack(d) !== 7'b1000000) begin
        miscompares++;
        $display("FAIL reset_release d%0d: got %b want 1000000", d, pack(d));
      end
    end
  endtask

  task automatic test_example();
    int dc, n;
    logic [18:0] v;
    words[0] = 16'hA5C3; avail[0] = 0;
    run_frame(0, 3'd5, 1, 1'b0, dc);
    vectors++;
    if (dc !== 21 + PAR) begin miscompares++; $display("FAIL example_done d0: got %0d want %0d", dc, 21 + PAR); end
    v = '0; n = 0;
    for (int c = 1; c < MAXC; c++) begin
      if (obs_valid[c] === 1'b1 && n < 19) begin
        v = {v[17:0], obs_bit[c]};
        n++;
      end
    end
    vectors++;
    if (v !== 19'b1011100001110100101 || n !== 19) begin
      miscompares++;
      $display("FAIL example_bits d0: got %b (%0d) want 1011100001110100101", v, n);
    end
  endtask

  task automatic test_bit_div3();
    int dc;
    logic [6:0] got;
    run_frame(1, 3'd2, 0, 1'b0, dc);
    vectors++;
    if (dc !== 11 + 3 * PAR) begin miscompares++; $display("FAIL div3_done d1: got %0d want %0d", dc, 11 + 3 * PAR); end
    got = {obs_valid[2], obs_valid[3], obs_valid[5], obs_bit[5], obs_bit[7], obs_valid[8], obs_bit[8]};
    vectors++;
    if (got !== 7'b1011110) begin miscompares++; $display("FAIL div3_slots d1: got %b want 1011110", got); end
  endtask

  task automatic test_underrun_gap();
    int dc;
    logic [5:0] got;
    words[0] = 16'($urandom); words[1] = 16'($urandom);
    avail[0] = 0; avail[1] = 24;
    run_frame(0, 3'($urandom_range(0, 7)), 2, 1'b0, dc);
    vectors++;
    if (dc !== 41 + PAR) begin miscompares++; $display("FAIL gap_done d0: got %0d want %0d", dc, 41 + PAR); end
    got = {obs_valid[20], obs_valid[21], obs_valid[22], obs_valid[23], obs_valid[24], obs_valid[25]};
    vectors++;
    if (got !== 6'b100001) begin miscompares++; $display("FAIL gap_shape d0: got %b want 100001", got); end
  endtask

  task automatic test_cmd_hold();
    int dc, w;
    words[0] = 16'($urandom); avail[0] = 0;
    run_frame(0, 3'($urandom_range(0, 7)), 1, 1'b1, dc);
    w = 0;
    while (done[0] !== 1'b1 && w < 60) begin
      @(negedge clk);
      w++;
    end
    vectors++;
    if (done[0] !== 1'b1) begin miscompares++; $display("FAIL hold_second_frame d0: got done=%b want 1", done[0]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_data();
    int wi, w, dc;
    logic bad;
    words[0] = 16'($urandom); words[1] = 16'($urandom);
    @(negedge clk);
    w = 0;
    while (cmd_ready[0] !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    cmd_valid[0] = 1'b1; cmd_id[0] = 3'($urandom_range(0, 7)); cmd_len[0] = 8'd2;
    wi = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      wd_valid[0] = (wi < 2);
      wd_data[0] = words[(wi < 2) ? wi : 0];
      if (wd_valid[0] && wd_ready[0] === 1'b1) wi++;
    end
    vectors++;
    if (cfg_bit_out_valid[0] !== 1'b1) begin miscompares++; $display("FAIL mid_data_valid d0: got %b want 1", cfg_bit_out_valid[0]); end
    crst_n = 1'b0;
    #1;
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (pack(0) !== 7'b1000000) bad = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (bad) begin miscompares++; $display("FAIL reset_mid_data d0: got %b want 1000000", pack(0)); end
    wd_valid[0] = 1'b0;
    crst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if ({cfg_out_start[0], cfg_bit_out_valid[0], busy[0], cmd_ready[0]} !== 4'b0001) bad = 1'b1;
    end
    vectors++;
    if (bad) begin miscompares++; $display("FAIL post_reset_quiet d0: got %b want 0001", {cfg_out_start[0], cfg_bit_out_valid[0], busy[0], cmd_ready[0]}); end
    words[0] = 16'($urandom); avail[0] = 0;
    run_frame(0, 3'($urandom_range(0, 7)), 1, 1'b0, dc);
    vectors++;
    if (obs_start[1] !== 1'b1) begin miscompares++; $display("FAIL restart_start d0: got %b want 1", obs_start[1]); end
  endtask

  task automatic test_random();
    int d, div, len, dc;
    for (int n = 0; n < 10; n++) begin
      d = n % 2;
      div = (d == 0) ? 1 : 3;
      len = $urandom_range(0, 3);
      for (int w = 0; w < 8; w++) begin
        words[w] = 16'($urandom);
        avail[w] = $urandom_range(0, 12 + w * 16 * div + 8 * div);
      end
      run_frame(d, 3'($urandom_range(0, 7)), len, 1'b0, dc);
    end
  endtask

`ifdef CFG_CHAIN_DRIVER_PARITY_EN
  task automatic test_parity();
    int dc;
    words[0] = 16'h0001; avail[0] = 0;
    run_frame(0, 3'd7, 1, 1'b0, dc);
    vectors++;
    if (dc !== 22) begin miscompares++; $display("FAIL parity_done d0: got %0d want 22", dc); end
    vectors++;
    if ({obs_valid[21], obs_bit[21]} !== 2'b10) begin
      miscompares++;
      $display("FAIL parity_bit d0: got %b want 10", {obs_valid[21], obs_bit[21]});
    end
  endtask
`endif

  initial begin
    vectors = 0; miscompares = 0;
    crst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0; cmd_id[d] = '0; cmd_len[d] = '0; wd_valid[d] = 1'b0; wd_data[d] = '0;
    end
    for (int w = 0; w < 8; w++) begin
      words[w] = '0;
      avail[w] = 0;
    end
    test_reset();
    test_example();
    test_bit_div3();
    test_underrun_gap();
    test_cmd_hold();
    test_reset_mid_data();
    test_random();
`ifdef CFG_CHAIN_DRIVER_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
